// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the byte-serial add/subtract engine.
//   WIDTH_DEF : default slice width in bits
//   mode_t    : arithmetic mode of an operation (ADD / SUB)
//   state_t   : operation-tracking FSM states (IDLE / BUSY)
// -----------------------------------------------------------------------------
package addsub_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage : addsub_pkg

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational WIDTH-bit slice of a multi-precision adder/subtractor.
// Subtraction is done as A + ~B + cin, so the caller supplies an inverted
// borrow as cin on the first slice and chains the raw carry afterwards.
// Ports:
//   a, b  in  WIDTH  operand slices
//   mode  in  mode_t ADD: B used as-is, SUB: B inverted
//   cin   in  1      chain input (already carry-polarity)
//   sum   out WIDTH  result slice
//   cout  out 1      raw carry out of the slice (not borrow-adjusted)
//   ovf   out 1      signed overflow of this slice treated as the top slice
// -----------------------------------------------------------------------------
module addsub_slice
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  mode_t            mode,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] bx;
   logic [WIDTH:0]   full;

   always_comb begin
      bx   = (mode == SUB) ? ~b : b;
      full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
      sum  = full[WIDTH-1:0];
      cout = full[WIDTH];
      // Overflow: both addends share a sign and the result sign differs.
      ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule : addsub_slice

// File: rtl/serial_addsub_engine.sv
// -----------------------------------------------------------------------------
// serial_addsub_engine
// Byte-serial multi-precision adder/subtractor. Operands arrive LSB-first as
// WIDTH-bit slices; each accepted beat produces one result slice one cycle
// later, with carry/borrow chained between beats.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. in_ready = !out_valid | out_ready, i.e. a single output register and
// no skid buffer; while the output stalls, nothing inside the engine moves.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_first, in_last     operation framing (LS slice / MS slice)
//   in_sub, in_cin        mode and carry/borrow-in, sampled on first beat
//   in_a, in_b            operand slices
//   out_valid/out_ready   output handshake
//   out_data, out_last    result slice and MS-slice marker
//   out_cout, out_zero,
//   out_ovf               end-of-operation flags, zero except on last beat
//   fsm_state             current operation-tracking state (observability)
// -----------------------------------------------------------------------------
module serial_addsub_engine
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_first,
   input  logic             in_last,
   input  logic             in_sub,
   input  logic             in_cin,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_ovf,
   output state_t           fsm_state
);

   state_t           state_q;
   state_t           state_d;
   mode_t            mode_q;
   logic             carry_q;
   logic             zero_acc_q;

   logic             accept;
   logic             first_beat;
   mode_t            mode_eff;
   logic             c0;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;
   logic             zero_next;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign fsm_state = state_q;

   // Any beat accepted in IDLE opens a new operation, as does in_first while
   // BUSY (which silently abandons the open one).
   assign first_beat = (state_q == IDLE) || in_first;

   always_comb begin
      mode_eff  = mode_q;
      c0        = carry_q;
      zero_next = zero_acc_q;
      if (first_beat) begin
         mode_eff = in_sub ? SUB : ADD;
         // Subtraction adds ~B, so a borrow-in of 0 means a carry-in of 1.
         c0       = in_sub ? ~in_cin : in_cin;
      end
      zero_next = (first_beat || zero_acc_q) && (sum == '0);
   end

   addsub_slice #(
      .WIDTH (WIDTH)
   ) u_slice (
      .a    (in_a),
      .b    (in_b),
      .mode (mode_eff),
      .cin  (c0),
      .sum  (sum),
      .cout (carry),
      .ovf  (ovf)
   );

   // FSM: state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = in_last ? IDLE : BUSY;
      end
   end

   // Chain state and output register. Everything changes only on an
   // accepted beat; a consumed output with no new beat just drops valid.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         mode_q     <= ADD;
         carry_q    <= 1'b0;
         zero_acc_q <= 1'b1;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_cout   <= 1'b0;
         out_zero   <= 1'b0;
         out_ovf    <= 1'b0;
      end else if (accept) begin
         mode_q     <= mode_eff;
         carry_q    <= carry;
         zero_acc_q <= zero_next;
         out_valid  <= 1'b1;
         out_data   <= sum;
         out_last   <= in_last;
         out_cout   <= in_last && ((mode_eff == SUB) ? ~carry : carry);
         out_zero   <= in_last && zero_next;
         out_ovf    <= in_last && ovf;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule : serial_addsub_engine
